// File: rtl/ram_access_sequencer.sv
// ram_access_sequencer
//   Sequences every access to the byte-wide on-chip RAM for two requesters:
//   instruction fetch (word reads) and data (byte/half/word, read or write).
//   Arbitrates round-robin when both request at once, rejects misaligned,
//   illegal-length or out-of-range requests without touching the RAM, and splits
//   legal requests into little-endian byte beats, one beat per cycle.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   i_req/i_addr                  fetch request (always a word read)
//   i_ack/i_rdata/i_err           fetch completion pulse, word, reject flag
//   d_req/d_we/d_len/d_addr/d_wdata   data request (len 00 byte, 01 half, 10 word)
//   d_ack/d_rdata/d_err           data completion pulse, zero-extended read, reject flag
//   ram_addr/ram_we/ram_wdata     byte port to RAM
//   ram_rdata                     RAM read byte, combinational from ram_addr
//   busy                          high whenever a transaction is in progress

module ram_access_sequencer #(
    parameter int unsigned RAM_WIDTH = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_len,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StBeat, StErr, StResp} state_e;

    state_e      state;
    logic        port_d;        // granted port: 1 = data, 0 = fetch
    logic        last_grant_d;  // round-robin memory: 1 = data was granted last
    logic [31:0] addr_q;
    logic        we_q;
    logic [1:0]  last_q;        // index of final beat (n-1)
    logic [31:0] wdata_q;
    logic [1:0]  beat_q;
    logic [31:0] rbuf_q;

    // Request selection and checking, only meaningful in StIdle.
    logic        pick_d;
    logic [31:0] sel_addr;
    logic [1:0]  sel_len;
    logic        sel_we;
    logic [1:0]  sel_last;
    logic        reject;

    always_comb begin
        pick_d   = d_req && (!i_req || !last_grant_d);
        sel_addr = pick_d ? d_addr : i_addr;
        sel_len  = pick_d ? d_len : 2'b10;
        sel_we   = pick_d && d_we;
        // byte -> 0, half -> 1, word -> 3
        sel_last = {sel_len[1], sel_len[1] | sel_len[0]};
        reject   = (sel_len == 2'b11)
                || (sel_len == 2'b01 && sel_addr[0])
                || (sel_len == 2'b10 && sel_addr[1:0] != 2'b00)
                || ((sel_addr >> RAM_WIDTH) != 32'd0);
    end

    // Beat datapath.
    logic [1:0]  next_beat;
    logic [31:0] wshift;
    logic [31:0] rbuf_next;

    always_comb begin
        next_beat = beat_q + 2'd1;
        wshift    = wdata_q >> {next_beat, 3'b000};
        // rbuf is cleared at grant, so OR-ing each byte in leaves upper bytes zero.
        rbuf_next = rbuf_q | ({24'd0, ram_rdata} << {beat_q, 3'b000});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= StIdle;
            port_d       <= 1'b0;
            last_grant_d <= 1'b0;
            addr_q       <= 32'd0;
            we_q         <= 1'b0;
            last_q       <= 2'd0;
            wdata_q      <= 32'd0;
            beat_q       <= 2'd0;
            rbuf_q       <= 32'd0;
            i_ack        <= 1'b0;
            i_err        <= 1'b0;
            i_rdata      <= 32'd0;
            d_ack        <= 1'b0;
            d_err        <= 1'b0;
            d_rdata      <= 32'd0;
            ram_addr     <= 32'd0;
            ram_we       <= 1'b0;
            ram_wdata    <= 8'd0;
            busy         <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (i_req || d_req) begin
                        port_d       <= pick_d;
                        last_grant_d <= pick_d;
                        addr_q       <= sel_addr;
                        we_q         <= sel_we;
                        last_q       <= sel_last;
                        wdata_q      <= d_wdata;
                        beat_q       <= 2'd0;
                        rbuf_q       <= 32'd0;
                        busy         <= 1'b1;
                        if (reject) begin
                            state <= StErr;
                            if (pick_d) begin
                                d_ack <= 1'b1;
                                d_err <= 1'b1;
                            end else begin
                                i_ack <= 1'b1;
                                i_err <= 1'b1;
                            end
                        end else begin
                            // Present beat 0 in the first BEAT cycle.
                            state     <= StBeat;
                            ram_addr  <= sel_addr;
                            ram_we    <= sel_we;
                            ram_wdata <= sel_we ? d_wdata[7:0] : 8'd0;
                        end
                    end
                end

                StBeat: begin
                    if (!we_q) begin
                        rbuf_q <= rbuf_next;
                    end
                    if (beat_q == last_q) begin
                        state     <= StResp;
                        ram_addr  <= 32'd0;
                        ram_we    <= 1'b0;
                        ram_wdata <= 8'd0;
                        if (port_d) begin
                            d_ack <= 1'b1;
                            if (!we_q) begin
                                d_rdata <= rbuf_next;
                            end
                        end else begin
                            i_ack   <= 1'b1;
                            i_rdata <= rbuf_next;
                        end
                    end else begin
                        beat_q    <= next_beat;
                        ram_addr  <= addr_q + {30'd0, next_beat};
                        ram_wdata <= we_q ? wshift[7:0] : 8'd0;
                    end
                end

                StErr, StResp: begin
                    state <= StIdle;
                    i_ack <= 1'b0;
                    i_err <= 1'b0;
                    d_ack <= 1'b0;
                    d_err <= 1'b0;
                    busy  <= 1'b0;
                end

                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_access_sequencer.sv
// tb_ram_access_sequencer
//   Directed and randomized bench for ram_access_sequencer. A byte-array RAM
//   sits on the RAM port; a separate reference memory tracks what the RAM
//   should hold, and each transaction's latency, error flag, read data and
//   write beats are derived from it.

module tb_ram_access_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = 32'd0;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [1:0]  d_len = 2'd0;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [31:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        busy;

    ram_access_sequencer #(.RAM_WIDTH(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .i_err     (i_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_len     (d_len),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // RAM environment and write log.
    logic [7:0]  mem [4096];
    logic [7:0]  model_mem [4096];
    logic [39:0] wlog [$];

    assign ram_rdata = mem[ram_addr[11:0]];

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr[11:0]] <= ram_wdata;
            wlog.push_back({ram_addr, ram_wdata});
        end
    end

    int          checks = 0;
    int          passed = 0;
    logic [31:0] exp_i_rdata = 32'd0;
    logic [31:0] exp_d_rdata = 32'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One transaction on one port, checked against the reference memory.
    task automatic txn(input bit is_d, input logic we_in, input logic [1:0] len_in,
                       input logic [31:0] addr, input logic [31:0] wdata);
        int          n;
        int          cyc;
        int          nw;
        bit          bad;
        bit          got;
        logic        we;
        logic [1:0]  len;
        logic [31:0] exp;
        we  = is_d ? we_in : 1'b0;
        len = is_d ? len_in : 2'b10;
        n   = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
        bad = (len == 2'b11) || (len == 2'b01 && addr[0]) ||
              (len == 2'b10 && addr[1:0] != 2'b00) || (addr >= 32'h1000);
        exp = 32'd0;
        if (!bad && !we) begin
            for (int k = 0; k < n; k++) begin
                exp = exp | (32'(model_mem[int'(addr[11:0]) + k]) << (8 * k));
            end
        end
        @(negedge clk);
        wlog.delete();
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_len = len; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            got = is_d ? d_ack : i_ack;
        end
        d_req = 1'b0;
        i_req = 1'b0;
        chk("latency", 32'(cyc), bad ? 32'd1 : 32'(n + 1));
        chk("other_ack", 32'(is_d ? i_ack : d_ack), 32'd0);
        chk("err", 32'(is_d ? d_err : i_err), 32'(bad));
        chk("busy_ack", 32'(busy), 32'd1);
        chk("ram_idle", {ram_addr[30:0], ram_we}, 32'd0);
        if (!bad && !we) begin
            if (is_d) exp_d_rdata = exp;
            else exp_i_rdata = exp;
        end
        if (is_d) chk("d_rdata", d_rdata, exp_d_rdata);
        else chk("i_rdata", i_rdata, exp_i_rdata);
        nw = (!bad && we) ? n : 0;
        chk("nwrites", 32'(wlog.size()), 32'(nw));
        for (int k = 0; k < nw && k < wlog.size(); k++) begin
            chk("waddr", wlog[k][39:8], addr + 32'(k));
            chk("wbyte", {24'd0, wlog[k][7:0]}, {24'd0, wdata[8 * k +: 8]});
        end
        for (int k = 0; k < nw; k++) begin
            model_mem[int'(addr[11:0]) + k] = wdata[8 * k +: 8];
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_i_rdata = 32'd0;
        exp_d_rdata = 32'd0;
    endtask

    initial begin
        int          cyc;
        int          extra;
        logic [31:0] a;
        logic [1:0]  l;
        for (int k = 0; k < 4096; k++) begin
            mem[k]       = 8'd0;
            model_mem[k] = 8'd0;
        end

        // Reset state.
        #12;
        chk("rst_flags", {26'd0, i_ack, i_err, d_ack, d_err, ram_we, busy}, 32'd0);
        chk("rst_ram_addr", ram_addr, 32'd0);
        chk("rst_rdata", i_rdata | d_rdata | {24'd0, ram_wdata}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Word write, then half and byte reads of it.
        txn(1'b1, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF);
        chk("t1_mem", {mem[19], mem[18], mem[17], mem[16]}, 32'hDEADBEEF);
        txn(1'b1, 1'b0, 2'b01, 32'h12, 32'h0);
        chk("t2_half", d_rdata, 32'h0000DEAD);
        txn(1'b1, 1'b0, 2'b00, 32'h11, 32'h0);
        chk("t2_byte", d_rdata, 32'h000000BE);

        // Rejections.
        txn(1'b1, 1'b1, 2'b10, 32'h11, 32'h12345678);
        txn(1'b1, 1'b1, 2'b01, 32'h13, 32'h12345678);
        txn(1'b1, 1'b1, 2'b11, 32'h14, 32'h12345678);
        txn(1'b1, 1'b1, 2'b00, 32'h1000, 32'h12345678);
        txn(1'b0, 1'b0, 2'b10, 32'h2, 32'h0);
        chk("t3_mem", {mem[23], mem[22], mem[21], mem[20]}, 32'h0);

        // Simultaneous requests from reset alternate D, I, D, I.
        do_reset();
        i_req = 1'b1; i_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_len = 2'b10; d_addr = 32'h10;
        for (int g = 0; g < 4; g++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!(i_ack || d_ack) && cyc < 20);
            chk("arb_port", {30'd0, i_ack, d_ack}, (g % 2 == 0) ? 32'd1 : 32'd2);
            chk("arb_data", d_ack ? d_rdata : i_rdata, 32'hDEADBEEF);
        end
        i_req = 1'b0;
        d_req = 1'b0;
        exp_i_rdata = 32'hDEADBEEF;
        exp_d_rdata = 32'hDEADBEEF;

        // Reset during beat 2 of a word write.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_len = 2'b10; d_addr = 32'h20; d_wdata = 32'hAABBCCDD;
        repeat (3) @(negedge clk);
        chk("t5_beat2", {ram_addr[30:0], ram_we}, {31'h22, 1'b1});
        rst = 1'b1;
        #1;
        chk("t5_flags", {26'd0, i_ack, i_err, d_ack, d_err, ram_we, busy}, 32'd0);
        chk("t5_outs", ram_addr | d_rdata | i_rdata | {24'd0, ram_wdata}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        d_req = 1'b0;
        exp_i_rdata = 32'd0;
        exp_d_rdata = 32'd0;
        chk("t5_mem", {mem[35], mem[34], mem[33], mem[32]}, 32'h0000CCDD);
        model_mem[32] = 8'hDD;
        model_mem[33] = 8'hCC;
        txn(1'b1, 1'b0, 2'b10, 32'h20, 32'h0);

        // Held request restarts in the IDLE cycle after ack; dropped req gives one ack.
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h10;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!i_ack && cyc < 20);
        chk("t6_first", 32'(cyc), 32'd5);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!i_ack && cyc < 20);
        chk("t6_second", 32'(cyc), 32'd6);
        i_req = 1'b0;
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (i_ack || d_ack) extra++;
        end
        chk("t6_extra", 32'(extra), 32'd0);
        exp_i_rdata = 32'hDEADBEEF;

        // Request withdrawn before ack still completes.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_len = 2'b00; d_addr = 32'h13;
        @(negedge clk);
        d_req = 1'b0;
        @(negedge clk);
        chk("t6_drop_ack", {30'd0, d_ack, d_err}, 32'd2);
        chk("t6_drop_data", d_rdata, 32'h000000DE);
        exp_d_rdata = 32'h000000DE;

        // Randomized traffic.
        for (int t = 0; t < 150; t++) begin
            a = ($urandom_range(0, 9) == 0) ? (32'h1000 << $urandom_range(0, 19))
                                           : 32'($urandom_range(0, 63));
            l = 2'($urandom_range(0, 3));
            txn(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), l, a, $urandom);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
